// File: rtl/rfphoenix_icmiss_fsm_if.sv
// Instruction-cache miss fill bus: miss request in, memory read channel,
// and the data/tag array write port. master = fill FSM, slave = environment.
interface rfphoenix_icmiss_fsm_if #(
   parameter int BEATS = 8,
   parameter int WAYS  = 4
);
   logic                     miss_i;
   logic [31:0]              miss_adr_i;
   logic                     mem_req_o;
   logic [31:0]              mem_adr_o;
   logic                     mem_ack_i;
   logic                     mem_rdy_i;
   logic [127:0]             mem_dat_i;
   logic                     mem_err_i;
   logic                     line_wr_o;
   logic [BEATS*128-1:0]     line_dat_o;
   logic [6:0]               line_ndx_o;
   logic                     tag_wr_o;
   logic [31:0]              tag_ipo_o;
   logic [$clog2(WAYS)-1:0]  way_o;
   logic                     busy_o;
   logic                     done_o;
   logic                     err_o;

   modport master (
      input  miss_i, miss_adr_i, mem_ack_i, mem_rdy_i, mem_dat_i, mem_err_i,
      output mem_req_o, mem_adr_o, line_wr_o, line_dat_o, line_ndx_o,
             tag_wr_o, tag_ipo_o, way_o, busy_o, done_o, err_o
   );

   modport slave (
      output miss_i, miss_adr_i, mem_ack_i, mem_rdy_i, mem_dat_i, mem_err_i,
      input  mem_req_o, mem_adr_o, line_wr_o, line_dat_o, line_ndx_o,
             tag_wr_o, tag_ipo_o, way_o, busy_o, done_o, err_o
   );
endinterface

// File: rtl/rfphoenix_icmiss_fsm.sv
// I-cache miss handler: requests a 128-byte line, assembles BEATS data beats,
// writes line + tag into a round-robin victim way, or aborts on bus error.
module rfphoenix_icmiss_fsm #(
   parameter int BEATS = 8,
   parameter int WAYS  = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   rfphoenix_icmiss_fsm_if.master  bus
);
   localparam int CW = $clog2(BEATS);
   localparam int WW = $clog2(WAYS);

   typedef enum logic [2:0] {IDLE, REQ, FILL, WRITE, DONE} state_t;

   state_t               state;
   logic [CW-1:0]        cnt;
   logic [WW-1:0]        victim;
   logic [31:0]          adr;
   logic [BEATS*128-1:0] line;

   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= IDLE;
         cnt           <= '0;
         victim        <= '0;
         bus.mem_req_o <= 1'b0;
         bus.line_wr_o <= 1'b0;
         bus.tag_wr_o  <= 1'b0;
         bus.done_o    <= 1'b0;
         bus.err_o     <= 1'b0;
         bus.busy_o    <= 1'b0;
      end else begin
         bus.line_wr_o <= 1'b0;
         bus.tag_wr_o  <= 1'b0;
         bus.done_o    <= 1'b0;
         bus.err_o     <= 1'b0;
         case (state)
            IDLE: if (bus.miss_i) begin
               cnt           <= '0;
               state         <= REQ;
               bus.mem_req_o <= 1'b1;
               bus.busy_o    <= 1'b1;
            end
            REQ: if (bus.mem_err_i) begin
               state         <= IDLE;
               bus.mem_req_o <= 1'b0;
               bus.busy_o    <= 1'b0;
               bus.err_o     <= 1'b1;
            end else if (bus.mem_ack_i) begin
               state         <= FILL;
               bus.mem_req_o <= 1'b0;
            end
            // error wins over a coincident beat, which is then dropped
            FILL: if (bus.mem_err_i) begin
               state      <= IDLE;
               bus.busy_o <= 1'b0;
               bus.err_o  <= 1'b1;
            end else if (bus.mem_rdy_i) begin
               cnt <= cnt + 1'b1;
               if (cnt == CW'(BEATS-1)) begin
                  state         <= WRITE;
                  bus.line_wr_o <= 1'b1;
                  bus.tag_wr_o  <= 1'b1;
               end
            end
            WRITE: begin
               state      <= DONE;
               bus.done_o <= 1'b1;
            end
            DONE: begin
               state      <= IDLE;
               bus.busy_o <= 1'b0;
               victim     <= (victim == WW'(WAYS-1)) ? '0 : victim + 1'b1;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Address and line buffer carry no reset; contents only matter once filled.
   always_ff @(posedge clk) begin
      if (state == IDLE && bus.miss_i)
         adr <= bus.miss_adr_i & ~32'h7F;
      if (state == FILL && bus.mem_rdy_i && !bus.mem_err_i)
         line[{cnt, 7'd0} +: 128] <= bus.mem_dat_i;
   end

   assign bus.mem_adr_o  = adr;
   assign bus.tag_ipo_o  = adr;
   assign bus.line_ndx_o = adr[13:7];
   assign bus.way_o      = victim;
   assign bus.line_dat_o = line;
endmodule

// File: doc/rfphoenix_icmiss_fsm.md
RFPHOENIX_ICMISS_FSM -- requirements
Module: rfphoenix_icmiss_fsm

Interface
REQ-001 Parameters (name, default, meaning), one per line:
  BEATS  8  data beats per 128-byte cache line (16 bytes per beat)
  WAYS   4  associativity; way field 2 bits
REQ-002 Ports (name, direction, width, meaning), one per line:
  clk  in  1  clock
  rst  in  1  reset, synchronous, active-high
  miss_i  in  1  tag compare missed; fill request
  miss_adr_i  in  32  code address that missed
  mem_req_o  out  1  memory read request
  mem_adr_o  out  32  line-aligned request address
  mem_ack_i  in  1  request accepted by memory
  mem_rdy_i  in  1  data beat valid
  mem_dat_i  in  128  data beat
  mem_err_i  in  1  bus error on current transfer
  line_wr_o  out  1  data-array line write strobe
  line_dat_o  out  1024  assembled line, beat 0 at bits [127:0]
  line_ndx_o  out  7  line index, address bits [13:7]
  tag_wr_o  out  1  tag-array write strobe
  tag_ipo_o  out  32  line address to the tag array
  way_o  out  2  victim way for line and tag writes
  busy_o  out  1  fill in progress (state not IDLE)
  done_o  out  1  one-cycle fill-complete pulse
  err_o  out  1  one-cycle fill-aborted pulse

Function
REQ-003 The FSM SHALL have exactly the states IDLE, REQ, FILL, WRITE and DONE.
REQ-004 In IDLE with miss_i=1, the block SHALL latch miss_adr_i with bits [6:0] forced to zero, clear the beat counter and enter REQ on the next edge.
REQ-005 In REQ, mem_req_o SHALL be 1 and mem_adr_o SHALL equal the latched address.
REQ-006 In REQ, mem_req_o SHALL remain 1 until mem_ack_i=1; the ack edge SHALL move the FSM to FILL.
REQ-007 mem_req_o SHALL be 0 in every state other than REQ.
REQ-008 Data beats SHALL be accepted only in FILL; mem_rdy_i in any other state SHALL be ignored.
REQ-009 Each accepted beat SHALL be stored at line slot [cnt*128 +: 128]; the 3-bit counter SHALL then increment.
REQ-010 Acceptance of beat BEATS-1 (cnt=7) SHALL move the FSM to WRITE; the counter SHALL NOT wrap into a ninth beat.
REQ-011 In WRITE, line_wr_o and tag_wr_o SHALL each be 1 for exactly one cycle.
REQ-012 During that WRITE cycle:
  - line_ndx_o SHALL equal latched address bits [13:7].
  - tag_ipo_o SHALL equal the latched address.
  - way_o SHALL equal the victim way counter.
REQ-013 WRITE SHALL advance unconditionally to DONE.
REQ-014 In DONE, done_o SHALL be 1 for one cycle; the victim counter SHALL increment modulo 4 (3 wraps to 0); the FSM SHALL return to IDLE.
REQ-015 mem_err_i=1 in REQ or FILL SHALL, on the next edge:
  - move the FSM to IDLE and pulse err_o for one cycle;
  - leave the victim counter unchanged;
  - produce no line_wr_o or tag_wr_o pulse.
REQ-016 If mem_err_i and mem_rdy_i are both 1 in the same cycle, the error SHALL take priority and that beat SHALL be discarded.
REQ-017 miss_i and miss_adr_i SHALL be ignored while busy_o=1; a miss still asserted on return to IDLE SHALL start a new fill.
REQ-018 busy_o SHALL be 1 in REQ, FILL, WRITE and DONE, and 0 in IDLE.
REQ-019 Minimum latency, assuming ack one cycle after REQ entry and back-to-back beats, SHALL be 1 cycle to REQ, 1 cycle to ack, 8 FILL cycles and 1 WRITE cycle; done_o SHALL assert 11 cycles after the miss edge.

Reset
REQ-020 With rst=1 on a clock edge, the block SHALL:
  - enter IDLE, zero the beat counter and set the victim counter to 0;
  - drive mem_req_o, line_wr_o, tag_wr_o, done_o, err_o and busy_o to 0.
REQ-021 rst SHALL take priority over every other input, including mid-fill; an interrupted fill SHALL produce no writes.
REQ-022 line_dat_o and the latched address SHALL be don't-care after reset, with no reset value required.

Verification
REQ-023 Basic fill:
  - stimulus: miss_adr_i=0x0000_1234; ack 1 cycle after REQ entry; 8 consecutive beats with data 0..7.
  - response: mem_adr_o=0x0000_1200; line_ndx_o=0x24; tag_ipo_o=0x0000_1200; way_o=0; line_dat_o[127:0]=0; line_dat_o[1023:896]=7; done_o 11 cycles after the miss edge.
REQ-024 Gapped beats and delayed ack:
  - stimulus: ack 5 cycles late; one idle cycle between every beat.
  - response: mem_req_o held high for all 5 cycles; a single write pulse pair; data identical to the gap-free case.
REQ-025 Victim rotation: 5 back-to-back fills -> way_o sequence 0,1,2,3,0.
REQ-026 Bus error: mem_err_i on the 4th beat -> err_o pulse; no line_wr_o or tag_wr_o; next fill uses the same way.
REQ-027 Reset mid-fill: rst asserted after beat 3 -> busy_o=0 next cycle; no write strobes; next fill starts cleanly with way_o=0.
REQ-028 Busy-miss:
  - stimulus: a different miss_adr_i pulsed during FILL.
  - response: the latched address is unchanged; the second miss is served only after done_o if miss_i is still held.
